// File: rtl/reg_file_pkg.sv
// Shared widths, types and constants for the general-purpose register file.
// Pure definitions, no logic.
package reg_file_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2**ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: zero-register check, optional write bypass, output flop.
// Latency 1 cycle; holds its output while en or rd_en is low (no backpressure path).
module reg_file_read_port #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rf [2**ADDR_W],
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] dout
);
  import reg_file_pkg::*;

  logic [DATA_W-1:0] rdata;

  always_comb begin
    rdata = rf[addr];
`ifdef REGFILE_BYPASS_EN
    // Write-first: a same-edge write to this address wins over the stored word.
    if (wr_fire && (wr_addr == addr)) rdata = wr_data;
`endif
    if (addr == ADDR_W'(REG_ZERO)) rdata = '0;
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = &{1'b0, wr_fire, wr_addr, wr_data};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (en && rd_en) begin
      dout <= rdata;
    end
  end
endmodule

// File: rtl/reg_file.sv
// 32x32 register file, two registered read ports, one write port, r0 hardwired to 0.
// Read latency 1 cycle, write visible to reads issued on the next edge; REGFILE_BYPASS_EN makes same-edge reads write-first.
// No backpressure: en=0 freezes all state, readEn=0 holds the outputs.
module reg_file #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              readEn,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] readOut1,
  output logic [DATA_W-1:0] readOut2
);
  import reg_file_pkg::*;

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] rf [NREGS];
  logic              wr_fire;

  // rd=0 never fires, so rf[0] stays at its reset value of zero.
  assign wr_fire = en && writeEn && (rd != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wr_fire) begin
      rf[rd] <= dataIn;
    end
  end

  reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .rd_en   (readEn),
    .addr    (rs1),
    .rf      (rf),
    .wr_fire (wr_fire),
    .wr_addr (rd),
    .wr_data (dataIn),
    .dout    (readOut1)
  );

  reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .rd_en   (readEn),
    .addr    (rs2),
    .rf      (rf),
    .wr_fire (wr_fire),
    .wr_addr (rd),
    .wr_data (dataIn),
    .dout    (readOut2)
  );
endmodule

// File: tb/tb_reg_file.sv
// Directed vector bench for reg_file; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        reset, en, readEn, writeEn;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] dataIn;
  logic [31:0] readOut1, readOut2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .readEn   (readEn),
    .writeEn  (writeEn),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .dataIn   (dataIn),
    .readOut1 (readOut1),
    .readOut2 (readOut2)
  );

  typedef struct {
    string       name;
    logic        rst, en, re, we;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] din;
    logic        chk;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t tbl[$];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic vec_t mk(string name, logic rst, logic en_i, logic re, logic we,
                              logic [4:0] a1, logic [4:0] a2, logic [4:0] w,
                              logic [31:0] din, logic chk, logic [31:0] e1, logic [31:0] e2);
    vec_t v;
    v.name = name; v.rst = rst; v.en = en_i; v.re = re; v.we = we;
    v.rs1 = a1; v.rs2 = a2; v.rd = w; v.din = din;
    v.chk = chk; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst; en = v.en; readEn = v.re; writeEn = v.we;
    rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; dataIn = v.din;
    @(posedge clk);
    #1;
    if (v.chk) begin
      n_vec++;
      if (readOut1 !== v.e1) begin
        n_err++;
        $display("FAIL %s readOut1: got %h expected %h", v.name, readOut1, v.e1);
      end
      if (readOut2 !== v.e2) begin
        n_err++;
        $display("FAIL %s readOut2: got %h expected %h", v.name, readOut2, v.e2);
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; readEn = 1'b0; writeEn = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; dataIn = '0;

    // Reset state, preload, reset clears storage and outputs
    tbl.push_back(mk("reset_init",   1, 0, 0, 0,  0,  0, 0, 32'h0,        1, 32'h0, 32'h0));
    tbl.push_back(mk("",             0, 1, 0, 1,  0,  0, 5, 32'hDEADBEEF, 0, 32'h0, 32'h0));
    tbl.push_back(mk("preload_rd",   0, 1, 1, 0,  5,  5, 0, 32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF));
    tbl.push_back(mk("reset_outs",   1, 1, 1, 0,  5,  5, 0, 32'h0,        1, 32'h0, 32'h0));
    tbl.push_back(mk("reset_rf5",    0, 1, 1, 0,  5,  0, 0, 32'h0,        1, 32'h0, 32'h0));

    // Fill then read with crossed addresses
    for (int i = 0; i < 32; i++)
      tbl.push_back(mk("", 0, 1, 0, 1, 0, 0, 5'(i), 32'(i + 1), 0, 32'h0, 32'h0));
    for (int i = 0; i < 32; i++)
      tbl.push_back(mk($sformatf("fill_rd%0d", i), 0, 1, 1, 0, 5'(i), 5'(31 - i), 0, 32'h0, 1,
                       (i == 0) ? 32'h0 : 32'(i + 1), (i == 31) ? 32'h0 : 32'(32 - i)));

    // Zero register ignores writes
    tbl.push_back(mk("",             0, 1, 0, 1,  0,  0, 0, 32'hFFFFFFFF, 0, 32'h0, 32'h0));
    tbl.push_back(mk("zero_reg",     0, 1, 1, 0,  0,  1, 0, 32'h0,        1, 32'h0, 32'h2));
    tbl.push_back(mk("zero_same_edge", 0, 1, 1, 1, 0, 0, 0, 32'hFFFFFFFF, 1, 32'h0, 32'h0));

    // Enables
    tbl.push_back(mk("we0_read",     0, 1, 1, 0,  3,  4, 3, 32'h12345678, 1, 32'h4, 32'h5));
    tbl.push_back(mk("we0_rf3",      0, 1, 1, 0,  3,  3, 0, 32'h0,        1, 32'h4, 32'h4));
    tbl.push_back(mk("re0_hold",     0, 1, 0, 0, 10, 11, 0, 32'h0,        1, 32'h4, 32'h4));
    tbl.push_back(mk("en0_hold",     0, 0, 1, 1, 12, 13, 12, 32'h0000CAFE, 1, 32'h4, 32'h4));
    tbl.push_back(mk("en0_nowrite",  0, 1, 1, 0, 12, 13, 0, 32'h0,        1, 32'hD, 32'hE));

    // Same-edge read/write on each port
    tbl.push_back(mk("",             0, 1, 0, 1,  0,  0, 7, 32'hA,        0, 32'h0, 32'h0));
    tbl.push_back(mk("same_edge_p1", 0, 1, 1, 1,  7,  8, 7, 32'hB,        1, BYP ? 32'hB : 32'hA, 32'h9));
    tbl.push_back(mk("after_write",  0, 1, 1, 0,  7,  7, 0, 32'h0,        1, 32'hB, 32'hB));
    tbl.push_back(mk("same_edge_p2", 0, 1, 1, 1,  0,  8, 8, 32'hC,        1, 32'h0, BYP ? 32'hC : 32'h9));
    tbl.push_back(mk("after_write2", 0, 1, 1, 0,  8,  9, 0, 32'h0,        1, 32'hC, 32'hA));

    foreach (tbl[k]) apply(tbl[k]);

    // Reset coinciding with a write: the write is dropped and storage clears
    apply(mk("rst_mid_write", 1, 1, 1, 1, 9, 8, 9, 32'h55, 1, 32'h0, 32'h0));
    apply(mk("rst_rf9",       0, 1, 1, 0, 9, 8, 0, 32'h0,  1, 32'h0, 32'h0));
    apply(mk("",              0, 1, 0, 1, 0, 0, 9, 32'h66, 0, 32'h0, 32'h0));
    apply(mk("post_rst_wr",   0, 1, 1, 0, 9, 0, 0, 32'h0,  1, 32'h66, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
